// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin share of one iterative sqrt core with tagged, held results and a hang watchdog
module sqrt_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16,
  parameter int TIMEOUT   = 32,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_rad,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IW-1:0]            resp_id,
  output logic [WIDTH-1:0]         resp_root,
  output logic                     resp_ok,
  output logic                     core_start,
  output logic [WIDTH-1:0]         core_rad,
  input  logic                     core_done,
  input  logic                     core_valid,
  input  logic [WIDTH-1:0]         core_root,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  if (FRAC_BITS >= WIDTH || TIMEOUT <= WIDTH / 2 + 1) begin : g_bad_params
    $error("sqrt_arbiter: FRAC_BITS must be < WIDTH and TIMEOUT > WIDTH/2+1");
  end
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t            state;
  logic [IW-1:0]     rr_ptr, lat_id, gnt, idx;
  logic              found;
  logic [WIDTH-1:0]  rad;
  logic [CW-1:0]     wait_cnt;
  // Descending scan so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    found = 1'b0;
    gnt   = rr_ptr;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    rad = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt == IW'(k)) rad = req_rad[k*WIDTH +: WIDTH];
  end
  assign req_ready = (state == IDLE && found) ? NUM_REQ'(1) << gnt : '0;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lat_id      <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_root   <= '0;
      resp_ok     <= 1'b0;
      core_start  <= 1'b0;
      core_rad    <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          lat_id     <= gnt;
          core_rad   <= rad;
          rr_ptr     <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          core_start <= 1'b1;
          state      <= START;
        end
        START: begin
          core_start <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: if (core_done) begin
          resp_root  <= core_root;
          resp_ok    <= core_valid;
          resp_id    <= lat_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          timeout_err <= 1'b1;
          resp_root   <= '0;
          resp_ok     <= 1'b0;
          resp_id     <= lat_id;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed scenario tasks against a behavioural 16-cycle sqrt core model
module tb_sqrt_arbiter;
  localparam int N = 4, W = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_rad = '0;
  logic resp_valid, resp_ready = 1'b0, resp_ok, core_start, core_done, busy, timeout_err;
  logic [1:0] resp_id;
  logic [W-1:0] resp_root, core_rad, core_root;
  logic hang = 1'b0, stale = 1'b0, m_done = 1'b0;
  logic [4:0] m_cnt = '0;
  logic [W-1:0] m_root = '0;
  int pass = 0, total = 0, n_starts = 0, cyc = 0;
  always #5 clk = ~clk;
  sqrt_arbiter #(.NUM_REQ(N), .WIDTH(W), .FRAC_BITS(16), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rad(req_rad), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_root(resp_root),
    .resp_ok(resp_ok), .core_start(core_start), .core_rad(core_rad), .core_done(core_done),
    .core_valid(1'b1), .core_root(core_root), .busy(busy), .timeout_err(timeout_err));
  function automatic logic [31:0] isqrt(input logic [31:0] r);
    longint unsigned x = {16'd0, r, 16'd0};
    longint unsigned t;
    logic [31:0] res = '0;
    for (int b = 31; b >= 0; b--) begin
      t = longint'(res | (32'd1 << b));
      if (t * t <= x) res = res | (32'd1 << b);
    end
    return res;
  endfunction
  // Core model: done pulses 16 edges after the edge that sampled core_start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_done <= 1'b0;
    if (core_start) begin
      m_cnt <= 5'd16;
      n_starts <= n_starts + 1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1'b1;
      if (m_cnt == 1 && !hang) begin
        m_done <= 1'b1;
        m_root <= isqrt(core_rad);
      end
    end
  end
  assign core_done = m_done | stale;
  assign core_root = m_root;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin tick; lat++; end
  endtask
  task automatic test_reset;
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    tick; tick;
    total++; if ({resp_valid, resp_id, resp_root, resp_ok} !== 35'd0) $display("FAIL reset_resp: got %h want 0", {resp_valid, resp_id, resp_root, resp_ok}); else pass++;
    total++; if ({core_start, core_rad, busy, timeout_err, req_ready} !== 39'd0) $display("FAIL reset_ctrl: got %h want 0", {core_start, core_rad, busy, timeout_err, req_ready}); else pass++;
    rst = 1'b0;
  endtask
  task automatic test_single;
    int s0, lat;
    do_reset;
    s0 = n_starts;
    req_valid = 4'b0001; req_rad[0 +: 32] = 32'h0004_0000; #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_ready); else pass++;
    tick; req_valid = '0;
    total++; if ({req_ready, core_start, core_rad} !== {4'b0, 1'b1, 32'h0004_0000}) $display("FAIL single_start: got %h want %h", {req_ready, core_start, core_rad}, {4'b0, 1'b1, 32'h0004_0000}); else pass++;
    wait_resp(lat);
    total++; if (lat !== 19) $display("FAIL single_latency: got %0d want 19", lat); else pass++;
    total++; if ({resp_id, resp_root, resp_ok} !== {2'd0, 32'h0002_0000, 1'b1}) $display("FAIL single_result: got %h want %h", {resp_id, resp_root, resp_ok}, {2'd0, 32'h0002_0000, 1'b1}); else pass++;
    total++; if (n_starts - s0 !== 1) $display("FAIL single_start_count: got %0d want 1", n_starts - s0); else pass++;
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
    total++; if ({resp_valid, busy} !== 2'b00) $display("FAIL single_release: got %b want 00", {resp_valid, busy}); else pass++;
  endtask
  task automatic test_back_to_back;
    int ids[5] = '{0, 1, 2, 3, 0};
    logic [31:0] roots[5] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_6A09, 32'h0001_0000};
    int c, lat, last;
    do_reset;
    req_rad = {32'h0002_0000, 32'h0009_0000, 32'h0004_0000, 32'h0001_0000};
    req_valid = 4'hF; resp_ready = 1'b1; #1;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      c = 0;
      while (req_ready == 0 && c < 50) begin tick; c++; end
      total++; if (req_ready !== 4'(1 << ids[i])) $display("FAIL b2b_grant%0d: got %b want %b", i, req_ready, 4'(1 << ids[i])); else pass++;
      if (i > 0) begin
        total++; if (cyc - last !== 20) $display("FAIL b2b_period%0d: got %0d want 20", i, cyc - last); else pass++;
      end
      last = cyc;
      tick;
      wait_resp(lat);
      total++; if ({resp_valid, resp_id, resp_root, resp_ok} !== {1'b1, 2'(ids[i]), roots[i], 1'b1}) $display("FAIL b2b_result%0d: got %h want %h", i, {resp_valid, resp_id, resp_root, resp_ok}, {1'b1, 2'(ids[i]), roots[i], 1'b1}); else pass++;
      tick;
    end
    req_valid = '0; resp_ready = 1'b0;
  endtask
  task automatic test_backpressure;
    int c, lat;
    do_reset;
    req_valid = 4'b0001; req_rad[0 +: 32] = 32'h0009_0000; #1;
    c = 0;
    while (req_ready == 0 && c < 20) begin tick; c++; end
    tick;
    req_valid = 4'b0010; req_rad[32 +: 32] = 32'h0001_0000;
    wait_resp(lat);
    for (int i = 0; i < 10; i++) begin
      total++; if ({resp_valid, resp_id, resp_root, resp_ok, req_ready, core_start} !== {1'b1, 2'd0, 32'h0003_0000, 1'b1, 4'b0, 1'b0}) $display("FAIL bp_hold%0d: got %h want %h", i, {resp_valid, resp_id, resp_root, resp_ok, req_ready, core_start}, {1'b1, 2'd0, 32'h0003_0000, 1'b1, 4'b0, 1'b0}); else pass++;
      tick;
    end
    resp_ready = 1'b1; #1;
    total++; if (req_ready !== 4'b0000) $display("FAIL bp_handshake_cycle: got %b want 0000", req_ready); else pass++;
    tick; resp_ready = 1'b0;
    total++; if (req_ready !== 4'b0010) $display("FAIL bp_next_grant: got %b want 0010", req_ready); else pass++;
    tick; req_valid = '0;
    wait_resp(lat);
    total++; if ({resp_id, resp_root} !== {2'd1, 32'h0001_0000}) $display("FAIL bp_second: got %h want %h", {resp_id, resp_root}, {2'd1, 32'h0001_0000}); else pass++;
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
  endtask
  task automatic test_timeout;
    int lat;
    do_reset;
    hang = 1'b1;
    req_valid = 4'b1000; req_rad[96 +: 32] = 32'h0004_0000; #1;
    total++; if (req_ready !== 4'b1000) $display("FAIL to_grant: got %b want 1000", req_ready); else pass++;
    tick; req_valid = '0;
    wait_resp(lat);
    total++; if (lat !== 34) $display("FAIL to_latency: got %0d want 34", lat); else pass++;
    total++; if ({resp_valid, resp_ok, resp_root, timeout_err} !== {1'b1, 1'b0, 32'd0, 1'b1}) $display("FAIL to_result: got %h want %h", {resp_valid, resp_ok, resp_root, timeout_err}, {1'b1, 1'b0, 32'd0, 1'b1}); else pass++;
    resp_ready = 1'b1; tick; resp_ready = 1'b0; hang = 1'b0;
    req_valid = 4'b0001; req_rad[0 +: 32] = 32'h0009_0000; #1;
    tick; req_valid = '0;
    wait_resp(lat);
    total++; if ({lat[7:0], resp_ok, resp_root, timeout_err} !== {8'd19, 1'b1, 32'h0003_0000, 1'b1}) $display("FAIL to_recover: got %h want %h", {lat[7:0], resp_ok, resp_root, timeout_err}, {8'd19, 1'b1, 32'h0003_0000, 1'b1}); else pass++;
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
  endtask
  task automatic test_stale_done;
    int lat;
    stale = 1'b1;
    do_reset;
    tick; tick;
    total++; if ({resp_valid, busy} !== 2'b00) $display("FAIL stale_idle: got %b want 00", {resp_valid, busy}); else pass++;
    req_valid = 4'b0001; req_rad[0 +: 32] = 32'h0001_0000; #1;
    tick; req_valid = '0; stale = 1'b0;
    wait_resp(lat);
    total++; if ({lat[7:0], resp_root, resp_ok} !== {8'd19, 32'h0001_0000, 1'b1}) $display("FAIL stale_result: got %h want %h", {lat[7:0], resp_root, resp_ok}, {8'd19, 32'h0001_0000, 1'b1}); else pass++;
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
  endtask
  task automatic test_rst_mid;
    int lat;
    do_reset;
    req_valid = 4'b0010; req_rad[32 +: 32] = 32'h0004_0000; #1;
    tick; req_valid = '0;
    repeat (5) tick;
    rst = 1'b1; tick; rst = 1'b0;
    total++; if ({resp_valid, resp_root, resp_ok, core_start, core_rad, busy, dut.rr_ptr} !== 70'd0) $display("FAIL rst_mid_state: got %h want 0", {resp_valid, resp_root, resp_ok, core_start, core_rad, busy, dut.rr_ptr}); else pass++;
    req_valid = 4'b0100; req_rad[64 +: 32] = 32'h0009_0000; #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL rst_mid_grant: got %b want 0100", req_ready); else pass++;
    tick; req_valid = '0;
    wait_resp(lat);
    total++; if ({resp_id, resp_root, resp_ok} !== {2'd2, 32'h0003_0000, 1'b1}) $display("FAIL rst_mid_result: got %h want %h", {resp_id, resp_root, resp_ok}, {2'd2, 32'h0003_0000, 1'b1}); else pass++;
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
  endtask
  initial begin
    #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_stale_done;
    test_rst_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
